data_mem: RTL
=============

# data_mem

Data-memory responder for the 16-bit core. It sits at the far end of the execute stage's memory interface: it accepts word writes (`ram_wen`/`ram_data`), supplies read data that the execute stage samples as its RAM input for `LDR`/`POP`/`BLX`, and holds the downward-growing stack below address 0x20. It also offers a valid/ready dump port so a host or bench can stream memory contents out without stalling the core.

## Interface
- `DATA_W`, 16, data word width (shared `DATA_W` macro)
- `DEPTH`, 32, number of words; legal addresses 0..DEPTH-1
- `ADDR_W`, 5, index width, $clog2(DEPTH)

- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `ram_addr`  in  DATA_W  word address from decode (SP-derived for stack ops)
- `ram_wen`  in  1  write strobe from execute
- `ram_data`  in  DATA_W  write data from execute
- `ram_rdata`  out  DATA_W  combinational read data at `ram_addr`
- `addr_err`  out  1  sticky: access to an out-of-range address
- `err_clr`  in  1  clears `addr_err`
- `dump_req`  in  1  start a full-memory dump (pulse or level)
- `dump_valid`  out  1  dump word available
- `dump_ready`  in  1  consumer accepts dump word
- `dump_addr`  out  ADDR_W  index of the presented word
- `dump_data`  out  DATA_W  contents of `dump_addr`
- `dump_done`  out  1  one-cycle pulse after the last word is accepted

## Operation
- Storage: DEPTH x DATA_W register array, all words cleared to 0 on reset.
- Read: `ram_rdata` = mem[`ram_addr`] combinationally when `ram_addr` < DEPTH, else 0.
- Write: on a rising edge with `ram_wen`=1 and `ram_addr` < DEPTH, mem[`ram_addr`] <= `ram_data`.
- Out of range: with `ram_addr` >= DEPTH, writes are dropped. `addr_err` sets on the next edge if `ram_wen`=1, and also on a read. A read is the case `ram_wen`=0 with `rd_chk`; in this block every cycle with `ram_addr` >= DEPTH counts as an access, so `addr_err` sets on any out-of-range address.
- `addr_err` clears on `err_clr`; a same-cycle set takes priority over the clear.
- Dump FSM, three states:
  - IDLE: `dump_valid`=0. `dump_req`=1 moves to SEND with pointer=0.
  - SEND: `dump_valid`=1, `dump_addr`=pointer, `dump_data`=mem[pointer] (live). On `dump_valid`&&`dump_ready`, pointer increments. If pointer = DEPTH-1, go to DONE.
  - DONE: `dump_done`=1 for exactly one cycle, then return to IDLE. `dump_req` is ignored outside IDLE.
- The dump never blocks core writes. If a core write hits the presented index in the handshake cycle, the transferred word is the pre-write value. If the index is not yet accepted, the word shows the new value from the next cycle.

## Timing
- Reset values: `ram_rdata` reflects the zeroed array (0), `addr_err`=0, `dump_valid`=0, `dump_addr`=0, `dump_data`=0, `dump_done`=0, FSM in IDLE.
- Read latency is 0 cycles (combinational). Write-to-read latency is 1 edge.
- Read-during-write to the same address returns the old word in that cycle.
- Dump throughput is one word per cycle with `dump_ready` held high. A full dump takes DEPTH cycles in SEND plus 1 in DONE.
- `dump_ready` may toggle freely. While `dump_valid` is high and not yet accepted, `dump_addr` must stay stable; `dump_data` changes only if the core writes that word.
- Reset asserted mid-dump aborts immediately to IDLE and clears the array. No `dump_done` is issued.

## Structure
- Put `DATA_W`, `DEPTH`, `ADDR_W` and the dump state encodings (IDLE=2'd0, SEND=2'd1, DONE=2'd2) in the shared def header.
- Split out one sub-module, `mem_dump_fsm`, containing the pointer, the state register, and the handshake/done logic. The array, address check and `addr_err` stay in `data_mem`.

## Test plan
- Reset, then read addr 0x05: `ram_rdata`=0x0000, `addr_err`=0, `dump_valid`=0.
- Write 0xBEEF@0x1F, then read 0x1F next cycle: `ram_rdata`=0xBEEF. Check a same-cycle read of 0x1F still returns 0x0000.
- Write 0x1234@0x20: write dropped, `addr_err`=1 next cycle, `ram_rdata`=0. Assert `err_clr` with no error in that cycle: `addr_err`=0.
- Preload mem[i]=i+0x100, pulse `dump_req` with `dump_ready`=1: 32 words 0x0100..0x011F appear on consecutive cycles, then a 1-cycle `dump_done`.
- Dump with `dump_ready` toggling every other cycle while the core writes 0xAAAA to the currently presented index at handshake: the old value is transferred, addresses stay in order with no skips, and the run takes 64 cycles.
- Drop `reset_n` after 10 dumped words: `dump_valid`=0 at once, no `dump_done`, all words read 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared widths, sizes and dump FSM state encodings for the
// data-memory responder and its dump sequencer.
package data_mem_pkg;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SEND = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_t;

  // True when a core address indexes a real word of the array.
  function automatic logic addr_in_range(input logic [DATA_W-1:0] addr);
    return addr < DATA_W'(DEPTH);
  endfunction

endpackage

// File: rtl/mem_dump_fsm.sv
// mem_dump_fsm: walks the memory index space once per dump request and
// presents each index on a valid/ready port, then pulses done.
//
// Ports:
//   clk, reset_n       clock, async active-low reset
//   dump_req           start a dump (sampled only in IDLE)
//   dump_ready         consumer accepts the presented word
//   dump_valid         index on dump_addr is being presented
//   dump_addr          presented index (the pointer)
//   dump_done          one-cycle pulse after the last word is accepted
//
// state     | meaning
// DUMP_IDLE | no dump in progress, waiting for dump_req
// DUMP_SEND | presenting dump_addr, advancing on each handshake
// DUMP_DONE | last word accepted, dump_done high for this cycle
module mem_dump_fsm
  import data_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dump_req,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  dump_state_t state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= DUMP_IDLE;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_done  <= 1'b0;
    end else begin
      case (state)
        DUMP_IDLE: begin
          dump_done <= 1'b0;
          if (dump_req) begin
            state      <= DUMP_SEND;
            dump_valid <= 1'b1;
            dump_addr  <= '0;
          end
        end
        DUMP_SEND: begin
          if (dump_valid && dump_ready) begin
            if (dump_addr == LAST_IDX) begin
              state      <= DUMP_DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              dump_addr <= dump_addr + 1'b1;
            end
          end
        end
        DUMP_DONE: begin
          state     <= DUMP_IDLE;
          dump_done <= 1'b0;
        end
        default: begin
          state      <= DUMP_IDLE;
          dump_valid <= 1'b0;
          dump_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/data_mem.sv
// data_mem: word-addressed data memory for the 16-bit core, with a sticky
// out-of-range flag and a non-blocking valid/ready dump port.
//
// Ports:
//   clk, reset_n     clock, async active-low reset (clears the array)
//   ram_addr         core word address
//   ram_wen          core write strobe
//   ram_data         core write data
//   ram_rdata        combinational read of ram_addr (0 when out of range)
//   addr_err         sticky out-of-range access flag
//   err_clr          clears addr_err (a same-cycle set wins)
//   dump_req         start a full-memory dump
//   dump_valid/ready dump handshake
//   dump_addr        presented dump index
//   dump_data        live contents of dump_addr
//   dump_done        one-cycle pulse when the dump completes
module data_mem
  import data_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] ram_addr,
  input  logic              ram_wen,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] ram_rdata,
  output logic              addr_err,
  input  logic              err_clr,
  input  logic              dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic [ADDR_W-1:0] idx;

  assign in_range  = addr_in_range(ram_addr);
  assign idx       = ram_addr[ADDR_W-1:0];
  assign ram_rdata = in_range ? mem[idx] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (ram_wen && in_range) begin
      mem[idx] <= ram_data;
    end
  end

  // Any cycle with an out-of-range address is an access, read or write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_err <= 1'b0;
    end else if (!in_range) begin
      addr_err <= 1'b1;
    end else if (err_clr) begin
      addr_err <= 1'b0;
    end
  end

  mem_dump_fsm u_dump (
    .clk        (clk),
    .reset_n    (reset_n),
    .dump_req   (dump_req),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_done  (dump_done)
  );

  // Read live from the array so a core write before the handshake shows up,
  // while a write in the handshake cycle itself transfers the old word.
  assign dump_data = dump_valid ? mem[dump_addr] : '0;

endmodule
